mem_stage: RTL and testbench

Memory-access pipeline stage of the MIPS sram-like CPU. It sits between the execute stage and the write-back stage. It collects the `data_ok`/`rdata` response for the memory request the execute stage issued, then aligns and extends load data. It forwards the result to write-back over `ms_to_ws_bus`. It also drains responses still in flight when the pipeline is flushed, so a stale response is never matched to a younger instruction.

---
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and data bundle between execute, the data SRAM response port, mem_stage and write-back.
// Bus widths mirror mycpu.h; the guard keeps both files on one definition.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 80
`endif

interface mem_stage_if;
    logic                          ws_allowin;
    logic                          ms_allowin;
    logic                          es_to_ms_valid;
    logic [`ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
    logic                          es_req_issued;
    logic                          data_sram_data_ok;
    logic [31:0]                   data_sram_rdata;
    logic                          ws_ex_forward;
    logic                          ms_to_ws_valid;
    logic [`ES_TO_MS_BUS_WD-7:0]   ms_to_ws_bus;
    logic [37:0]                   ms_fwd_bus;
    logic                          ms_load_pending;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_issued,
               data_sram_data_ok, data_sram_rdata, ws_ex_forward,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_load_pending
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_issued,
               data_sram_data_ok, data_sram_rdata, ws_ex_forward,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_load_pending
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: waits for data_ok, aligns/extends loads, drains stale responses after flush.
// Non-memory ops pass in one cycle; a load leaves in its data_ok cycle if write-back is ready, else holds.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 80
`endif

module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  ms
);
    localparam int BW = `ES_TO_MS_BUS_WD;

    logic          ms_valid;
    logic          ms_got;
    logic [BW-1:0] ms_bus_r;
    logic [31:0]   ms_rdata_r;
    logic [1:0]    discard_cnt;

    logic [31:0]    ms_pc;
    logic [31:0]    ms_alu_result;
    logic [4:0]     ms_dest;
    logic           ms_gr_we;
    logic [4:0]     ms_load_op;
    logic           ms_mem_req;
    logic [BW-77:0] ms_pass;

    assign ms_pc         = ms_bus_r[31:0];
    assign ms_alu_result = ms_bus_r[63:32];
    assign ms_dest       = ms_bus_r[68:64];
    assign ms_gr_we      = ms_bus_r[69];
    assign ms_load_op    = ms_bus_r[74:70];
    assign ms_mem_req    = ms_bus_r[75];
    assign ms_pass       = ms_bus_r[BW-1:76];

    logic discarding;
    logic capture;
    logic own_outstanding;
    logic ms_ready_go;

    // A response is consumed by the drain counter before it can ever belong to this instruction.
    assign discarding      = ms.data_sram_data_ok && (discard_cnt != 2'd0);
    assign capture         = ms.data_sram_data_ok && (discard_cnt == 2'd0) &&
                             ms_valid && ms_mem_req && !ms_got;
    assign own_outstanding = ms_valid && ms_mem_req && !ms_got && !capture;

    assign ms_ready_go = !ms_mem_req || ms_got || (ms.data_sram_data_ok && discard_cnt == 2'd0);
    assign ms.ms_allowin      = !ms_valid || (ms_ready_go && ms.ws_allowin);
    assign ms.ms_to_ws_valid  = ms_valid && ms_ready_go && !ms.ws_ex_forward;
    assign ms.ms_load_pending = ms_valid && (ms_load_op != 5'd0) && !ms_got;

    logic [31:0] mem_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] final_result;

    assign mem_data = capture ? ms.data_sram_rdata : ms_rdata_r;
    assign half_sel = ms_alu_result[1] ? mem_data[31:16] : mem_data[15:0];

    always_comb begin
        byte_sel = mem_data[7:0];
        case (ms_alu_result[1:0])
            2'd1:    byte_sel = mem_data[15:8];
            2'd2:    byte_sel = mem_data[23:16];
            2'd3:    byte_sel = mem_data[31:24];
            default: byte_sel = mem_data[7:0];
        endcase
    end

    // load_op is one-hot {lb, lbu, lh, lhu, lw}
    always_comb begin
        final_result = ms_alu_result;
        if (ms_load_op[4])      final_result = {{24{byte_sel[7]}}, byte_sel};
        else if (ms_load_op[3]) final_result = {24'd0, byte_sel};
        else if (ms_load_op[2]) final_result = {{16{half_sel[15]}}, half_sel};
        else if (ms_load_op[1]) final_result = {16'd0, half_sel};
        else if (ms_load_op[0]) final_result = mem_data;
    end

    assign ms.ms_to_ws_bus = {ms_pass, ms_gr_we, ms_dest, final_result, ms_pc};
    assign ms.ms_fwd_bus   = {ms_valid && ms_gr_we, ms_dest, final_result};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            ms_got      <= 1'b0;
            ms_bus_r    <= '0;
            ms_rdata_r  <= 32'd0;
            discard_cnt <= 2'd0;
        end else if (ms.ws_ex_forward) begin
            // Every request still in flight (ours and execute's) must be drained later.
            ms_valid    <= 1'b0;
            ms_got      <= 1'b0;
            discard_cnt <= discard_cnt - {1'b0, discarding}
                                       + {1'b0, own_outstanding}
                                       + {1'b0, ms.es_req_issued};
        end else begin
            discard_cnt <= discard_cnt - {1'b0, discarding};
            if (ms.ms_allowin) begin
                ms_valid <= ms.es_to_ms_valid;
            end
            if (capture) begin
                ms_rdata_r <= ms.data_sram_rdata;
            end
            if (ms.es_to_ms_valid && ms.ms_allowin) begin
                ms_bus_r <= ms.es_to_ms_bus;
                ms_got   <= 1'b0;
            end else if (capture) begin
                ms_got <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back buses are queued at issue and checked on delivery.
module tb_mem_stage;
    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_LB   = 5'b10000;
    localparam logic [4:0] OP_LBU  = 5'b01000;
    localparam logic [4:0] OP_LH   = 5'b00100;
    localparam logic [4:0] OP_LW   = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [73:0] sb[$];

    mem_stage_if ms_if();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .ms    (ms_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                           input logic [4:0] dest, input logic gr_we,
                                           input logic [4:0] op, input logic mem_req,
                                           input logic [3:0] pass);
        return {pass, mem_req, op, gr_we, dest, alu, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ms_if.ws_allowin = 1'b1;
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.es_to_ms_bus = '0;
        ms_if.es_req_issued = 1'b0;
        ms_if.data_sram_data_ok = 1'b0;
        ms_if.data_sram_rdata = 32'd0;
        ms_if.ws_ex_forward = 1'b0;
        #12;
        n_cmp++; if (ms_if.ms_allowin !== 1'b1) begin n_bad++; $display("FAIL reset_allowin got=%b exp=1", ms_if.ms_allowin); end
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", ms_if.ms_to_ws_valid); end
        n_cmp++; if (ms_if.ms_load_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b exp=0", ms_if.ms_load_pending); end
        n_cmp++; if (ms_if.ms_fwd_bus[37] !== 1'b0) begin n_bad++; $display("FAIL reset_fwd_valid got=%b exp=0", ms_if.ms_fwd_bus[37]); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        logic [73:0] exp;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0010, 32'h0000_1234, 5'd3, 1'b1, OP_NONE, 1'b0, 4'h5);
        sb.push_back({4'h5, 1'b1, 5'd3, 32'h0000_1234, 32'hBFC0_0010});
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid got=%b exp=1", ms_if.ms_to_ws_valid); end
        n_cmp++; if (ms_if.ms_fwd_bus !== {1'b1, 5'd3, 32'h0000_1234}) begin n_bad++; $display("FAIL alu_fwd got=%h exp=%h", ms_if.ms_fwd_bus, {1'b1, 5'd3, 32'h0000_1234}); end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++; if (ms_if.ms_to_ws_bus !== exp) begin n_bad++; $display("FAIL alu_bus got=%h exp=%h", ms_if.ms_to_ws_bus, exp); end
        tick();
    endtask

    task automatic test_load_byte(input logic [4:0] op, input logic [31:0] result);
        logic [73:0] exp;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0100, 32'h0000_1003, 5'd5, 1'b1, op, 1'b1, 4'h0);
        sb.push_back({4'h0, 1'b1, 5'd5, result, 32'hBFC0_0100});
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ms_if.ms_load_pending !== 1'b1) begin n_bad++; $display("FAIL load_pending[%0d] got=%b exp=1", i, ms_if.ms_load_pending); end
            n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL load_wait_valid[%0d] got=%b exp=0", i, ms_if.ms_to_ws_valid); end
            tick();
        end
        ms_if.data_sram_data_ok = 1'b1;
        ms_if.data_sram_rdata = 32'h80FF_FF7F;
        #1;
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL load_valid got=%b exp=1", ms_if.ms_to_ws_valid); end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++; if (ms_if.ms_to_ws_bus !== exp) begin n_bad++; $display("FAIL load_bus got=%h exp=%h", ms_if.ms_to_ws_bus, exp); end
        tick();
        ms_if.data_sram_data_ok = 1'b0;
        #1;
        n_cmp++; if (ms_if.ms_load_pending !== 1'b0) begin n_bad++; $display("FAIL load_pending_after got=%b exp=0", ms_if.ms_load_pending); end
    endtask

    task automatic test_backpressure();
        logic [73:0] exp;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0200, 32'h0000_2002, 5'd9, 1'b1, OP_LH, 1'b1, 4'h3);
        exp = {4'h3, 1'b1, 5'd9, 32'hFFFF_8001, 32'hBFC0_0200};
        sb.push_back(exp);
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.ws_allowin = 1'b0;
        ms_if.data_sram_data_ok = 1'b1;
        ms_if.data_sram_rdata = 32'h8001_0000;
        #1;
        n_cmp++; if (ms_if.ms_allowin !== 1'b0) begin n_bad++; $display("FAIL bp_allowin got=%b exp=0", ms_if.ms_allowin); end
        tick();
        ms_if.data_sram_data_ok = 1'b0;
        ms_if.data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (ms_if.ms_to_ws_bus !== exp) begin n_bad++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, ms_if.ms_to_ws_bus, exp); end
            n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, ms_if.ms_to_ws_valid); end
            tick();
        end
        ms_if.ws_allowin = 1'b1;
        #1;
        n_cmp++; if (ms_if.ms_allowin !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%b exp=1", ms_if.ms_allowin); end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++; if (ms_if.ms_to_ws_bus !== exp) begin n_bad++; $display("FAIL bp_bus got=%h exp=%h", ms_if.ms_to_ws_bus, exp); end
        tick();
    endtask

    task automatic test_flush_discard();
        logic [73:0] exp;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0300, 32'h0000_3000, 5'd4, 1'b1, OP_LW, 1'b1, 4'h0);
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        tick();
        ms_if.ws_ex_forward = 1'b1;
        ms_if.es_req_issued = 1'b1;
        #1;
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got=%b exp=0", ms_if.ms_to_ws_valid); end
        tick();
        ms_if.ws_ex_forward = 1'b0;
        ms_if.es_req_issued = 1'b0;
        #1;
        n_cmp++; if (dut.discard_cnt !== 2'd2) begin n_bad++; $display("FAIL fl_discard_cnt got=%0d exp=2", dut.discard_cnt); end
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'h8000_0180, 32'h0000_3004, 5'd7, 1'b1, OP_LW, 1'b1, 4'hA);
        sb.push_back({4'hA, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h8000_0180});
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.data_sram_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ms_if.data_sram_rdata = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
            #1;
            n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL fl_drop_valid[%0d] got=%b exp=0", i, ms_if.ms_to_ws_valid); end
            n_cmp++; if (ms_if.ms_load_pending !== 1'b1) begin n_bad++; $display("FAIL fl_drop_pending[%0d] got=%b exp=1", i, ms_if.ms_load_pending); end
            tick();
        end
        ms_if.data_sram_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL fl_third_valid got=%b exp=1", ms_if.ms_to_ws_valid); end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++; if (ms_if.ms_to_ws_bus !== exp) begin n_bad++; $display("FAIL fl_third_bus got=%h exp=%h", ms_if.ms_to_ws_bus, exp); end
        tick();
        ms_if.data_sram_data_ok = 1'b0;
        #1;
        n_cmp++; if (dut.discard_cnt !== 2'd0) begin n_bad++; $display("FAIL fl_drained got=%0d exp=0", dut.discard_cnt); end
    endtask

    task automatic test_flush_same_cycle();
        logic [73:0] exp;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0400, 32'h0000_4000, 5'd6, 1'b1, OP_LW, 1'b1, 4'h0);
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.data_sram_data_ok = 1'b1;
        ms_if.data_sram_rdata = 32'h5555_AAAA;
        ms_if.ws_ex_forward = 1'b1;
        #1;
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL sc_valid got=%b exp=0", ms_if.ms_to_ws_valid); end
        tick();
        ms_if.data_sram_data_ok = 1'b0;
        ms_if.ws_ex_forward = 1'b0;
        #1;
        n_cmp++; if (dut.discard_cnt !== 2'd0) begin n_bad++; $display("FAIL sc_discard_cnt got=%0d exp=0", dut.discard_cnt); end
        n_cmp++; if (dut.ms_got !== 1'b0) begin n_bad++; $display("FAIL sc_got got=%b exp=0", dut.ms_got); end
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL sc_after_valid got=%b exp=0", ms_if.ms_to_ws_valid); end
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0408, 32'h0000_0BAD, 5'd2, 1'b0, OP_NONE, 1'b0, 4'h1);
        sb.push_back({4'h1, 1'b0, 5'd2, 32'h0000_0BAD, 32'hBFC0_0408});
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        #1;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_cmp++; if (ms_if.ms_to_ws_bus !== exp || ms_if.ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL sc_next_bus got=%h/%b exp=%h/1", ms_if.ms_to_ws_bus, ms_if.ms_to_ws_valid, exp); end
        tick();
    endtask

    task automatic test_async_reset();
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'hBFC0_0500, 32'h0000_5000, 5'd8, 1'b1, OP_LW, 1'b1, 4'h0);
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        ms_if.ws_ex_forward = 1'b1;
        tick();
        ms_if.ws_ex_forward = 1'b0;
        ms_if.es_to_ms_valid = 1'b1;
        ms_if.es_to_ms_bus = mk_bus(32'h8000_0180, 32'h0000_5004, 5'd8, 1'b1, OP_LW, 1'b1, 4'h0);
        tick();
        ms_if.es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (dut.discard_cnt !== 2'd1 || ms_if.ms_load_pending !== 1'b1) begin n_bad++; $display("FAIL ar_setup got=%0d/%b exp=1/1", dut.discard_cnt, ms_if.ms_load_pending); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ms_if.ms_allowin !== 1'b1) begin n_bad++; $display("FAIL ar_allowin got=%b exp=1", ms_if.ms_allowin); end
        n_cmp++; if (ms_if.ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got=%b exp=0", ms_if.ms_to_ws_valid); end
        n_cmp++; if (ms_if.ms_load_pending !== 1'b0) begin n_bad++; $display("FAIL ar_pending got=%b exp=0", ms_if.ms_load_pending); end
        n_cmp++; if (ms_if.ms_fwd_bus[37] !== 1'b0) begin n_bad++; $display("FAIL ar_fwd_valid got=%b exp=0", ms_if.ms_fwd_bus[37]); end
        n_cmp++; if (dut.discard_cnt !== 2'd0) begin n_bad++; $display("FAIL ar_discard_cnt got=%0d exp=0", dut.discard_cnt); end
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte(OP_LB, 32'hFFFF_FF80);
        test_load_byte(OP_LBU, 32'h0000_0080);
        test_backpressure();
        test_flush_discard();
        test_flush_same_cycle();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
